fp_operand_unpack: RTL and testbench
====================================

# fp_operand_unpack

Input-side counterpart of the multiplier's result packer. Accepts a pair of IEEE-754 single-precision operands over a valid/ready handshake and classifies each one. It splits each operand into sign, extended exponent and 24-bit mantissa with the hidden bit made explicit. Denormal mantissas are normalized iteratively, one bit per cycle, so the multiplier datapath always sees a leading 1. Sits between the operand registers and the mantissa multiplier / exponent adder.

## Interface
- No parameters; format fixed to binary32.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair; equals (state==IDLE).
- op_a, op_b  in  32  IEEE-754 single operands.
- out_valid  out  1  unpacked pair available; equals (state==DONE).
- out_ready  in  1  consumer accepts the pair.
- sign_a, sign_b  out  1  operand sign.
- exp_a, exp_b  out  10  two's-complement biased exponent; may go negative after normalization.
- mant_a, mant_b  out  24  mantissa with explicit leading bit.
- zero_a/b, denorm_a/b, inf_a/b, nan_a/b, snan_a/b  out  1 each  class flags.
- out_inv  out  1  multiply is invalid: (inf_a&zero_b) | (zero_a&inf_b) | snan_a | snan_b.

## Operation
- States: IDLE, NORM, DONE. Reset state is IDLE.
- All registered outputs reset to 0. in_ready is 1 and out_valid is 0 during and after reset.
- On accept (IDLE & in_valid), per operand with E=op[30:23], F=op[22:0]:
  - Always: sign=op[31].
  - E=0, F=0: zero=1, exp=0, mant=0.
  - E=0, F≠0: denorm=1, exp=1, mant={1'b0,F}; needs normalization.
  - E=255, F=0: inf=1, exp=255, mant={1'b1,F}.
  - E=255, F≠0: nan=1; snan=~F[22]; exp=255, mant={1'b1,F}.
  - Otherwise: exp=E, mant={1'b1,F}.
  - out_inv is computed from the incoming flags and registered at accept.
- IDLE transitions:
  - To NORM if either operand is denormal.
  - To DONE otherwise.
- NORM, each cycle, for each operand with denorm=1 and mant[23]=0:
  - mant <= mant<<1; exp <= exp-1.
  - Operands already normalized hold their values.
  - Go to DONE in the cycle where both post-shift mants have bit 23 set, or are not denormal.
- Both operands shift in parallel. NORM length is max(k_a,k_b), where k is the leading-zero count of {0,F}, range 1..23.
- Final denormal exponent is 1-k: minimum -22 (10'h3EA), maximum 0.
- Class flags are not altered by normalization; denorm stays 1.
- DONE: all outputs are held stable. DONE -> IDLE when out_ready=1.
- A new pair cannot be accepted in the same cycle as the out handshake.
- in_valid is ignored outside IDLE. Operand inputs are sampled only at accept.

## Timing
- Accept at clock edge T.
- Non-denormal pair: out_valid=1 from T+1.
- Denormal pair: out_valid=1 from T+1+max(k_a,k_b); worst case T+24.
- Maximum throughput: one pair per 2 cycles, with out_ready held high.
- Backpressure: out_valid stays 1 and all data and flags stay constant until out_ready=1. in_ready stays 0 throughout.
- Reset asserted mid-NORM or mid-DONE:
  - State returns to IDLE and all outputs clear asynchronously.
  - The in-flight pair is discarded and is never presented.
- out_* values are only meaningful while out_valid=1. Intermediate values during NORM are unspecified to the consumer.

## Test plan
- a=0x3F800000, b=0x40000000, out_ready=1 -> out_valid at T+1; exp_a=127, exp_b=128, mants=0x800000, all flags 0, out_inv=0; in_ready back to 1 at T+2.
- a=0x00000001, b=0x3F800000 -> out_valid at T+24; exp_a=10'h3EA (-22), mant_a=0x800000, denorm_a=1; b unchanged (exp 127).
- a=0x00400000, b=0x80200000 -> k=1 and k=2; out_valid at T+3; exp_a=0, exp_b=-1 (10'h3FF), mant_a=mant_b=0x800000, sign_b=1.
- a=0x7F800000, b=0x80000000 -> inf_a=1, zero_b=1, sign_b=1, out_inv=1 at T+1. Repeat with a=0x7FA00000 (snan_a=1, out_inv=1) and a=0x7FC00000 (nan_a=1, snan_a=0, out_inv=0 with b=1.0).
- out_ready held 0 for 10 cycles after out_valid, with in_valid toggling and op_a changing -> outputs constant, in_ready=0, no new accept; release -> IDLE next cycle.
- Assert rst_n=0 for 1 cycle during NORM of a=0x00000001 -> all outputs 0, in_ready=1; next pair 1.0/1.0 completes normally at T+1.

Source files
------------

// File: rtl/fp_operand_unpack_if.sv
// Operand-pair handshake bus for fp_operand_unpack: operand pair in, unpacked
// fields and class flags out, plus a state tap for checkers.
interface fp_operand_unpack_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic        sign_a;
  logic        sign_b;
  logic [9:0]  exp_a;
  logic [9:0]  exp_b;
  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic        zero_a;
  logic        zero_b;
  logic        denorm_a;
  logic        denorm_b;
  logic        inf_a;
  logic        inf_b;
  logic        nan_a;
  logic        nan_b;
  logic        snan_a;
  logic        snan_b;
  logic        out_inv;
  logic [1:0]  dbg_state;

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b,
           zero_a, zero_b, denorm_a, denorm_b, inf_a, inf_b, nan_a, nan_b,
           snan_a, snan_b, out_inv, dbg_state
  );

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b,
           zero_a, zero_b, denorm_a, denorm_b, inf_a, inf_b, nan_a, nan_b,
           snan_a, snan_b, out_inv, dbg_state
  );
endinterface

// File: rtl/fp_operand_unpack.sv
// Unpacks and classifies a pair of binary32 operands; denormal mantissas are
// normalized one bit per cycle so the multiplier always sees a leading 1.
module fp_operand_unpack (
  input logic               clk,
  input logic               rst_n,
  fp_operand_unpack_if.slave bus
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds with its data stable until that edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic        zero;
    logic        denorm;
    logic        inf;
    logic        nan;
    logic        snan;
  } opnd_t;

  state_t state, state_next;
  opnd_t  reg_a, reg_b, nxt_a, nxt_b;
  logic   inv_r, inv_next;

  function automatic opnd_t unpack(input logic [31:0] op);
    opnd_t u;
    u      = '0;
    u.sign = op[31];
    if (op[30:23] == 8'h00) begin
      if (op[22:0] == 23'd0) begin
        u.zero = 1'b1;
      end else begin
        // Denormals start at the minimum normal exponent; NORM pulls it down.
        u.denorm = 1'b1;
        u.exp    = 10'd1;
        u.mant   = {1'b0, op[22:0]};
      end
    end else if (op[30:23] == 8'hFF) begin
      u.exp  = 10'd255;
      u.mant = {1'b1, op[22:0]};
      if (op[22:0] == 23'd0) begin
        u.inf = 1'b1;
      end else begin
        u.nan  = 1'b1;
        u.snan = ~op[22];
      end
    end else begin
      u.exp  = {2'b00, op[30:23]};
      u.mant = {1'b1, op[22:0]};
    end
    return u;
  endfunction

  always_comb begin
    state_next = state;
    nxt_a      = reg_a;
    nxt_b      = reg_b;
    inv_next   = inv_r;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          nxt_a    = unpack(bus.op_a);
          nxt_b    = unpack(bus.op_b);
          inv_next = (nxt_a.inf & nxt_b.zero) | (nxt_a.zero & nxt_b.inf) |
                     nxt_a.snan | nxt_b.snan;
          state_next = (nxt_a.denorm | nxt_b.denorm) ? NORM : DONE;
        end
      end
      NORM: begin
        if (reg_a.denorm && !reg_a.mant[23]) begin
          nxt_a.mant = {reg_a.mant[22:0], 1'b0};
          nxt_a.exp  = reg_a.exp - 10'd1;
        end
        if (reg_b.denorm && !reg_b.mant[23]) begin
          nxt_b.mant = {reg_b.mant[22:0], 1'b0};
          nxt_b.exp  = reg_b.exp - 10'd1;
        end
        // Leave as soon as the post-shift mantissas are both normalized.
        if ((!nxt_a.denorm || nxt_a.mant[23]) && (!nxt_b.denorm || nxt_b.mant[23]))
          state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      reg_a <= '0;
      reg_b <= '0;
      inv_r <= 1'b0;
    end else begin
      state <= state_next;
      reg_a <= nxt_a;
      reg_b <= nxt_b;
      inv_r <= inv_next;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.dbg_state = state;
  assign bus.out_inv   = inv_r;

  assign bus.sign_a   = reg_a.sign;
  assign bus.exp_a    = reg_a.exp;
  assign bus.mant_a   = reg_a.mant;
  assign bus.zero_a   = reg_a.zero;
  assign bus.denorm_a = reg_a.denorm;
  assign bus.inf_a    = reg_a.inf;
  assign bus.nan_a    = reg_a.nan;
  assign bus.snan_a   = reg_a.snan;

  assign bus.sign_b   = reg_b.sign;
  assign bus.exp_b    = reg_b.exp;
  assign bus.mant_b   = reg_b.mant;
  assign bus.zero_b   = reg_b.zero;
  assign bus.denorm_b = reg_b.denorm;
  assign bus.inf_b    = reg_b.inf;
  assign bus.nan_b    = reg_b.nan;
  assign bus.snan_b   = reg_b.snan;

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Directed bench for fp_operand_unpack: class decode, denormal normalization
// latency, backpressure hold and mid-flight reset.
module tb_fp_operand_unpack;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fp_operand_unpack_if bus ();

  fp_operand_unpack dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one pair; returns just after the accept edge (#1 later).
  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // flags order: {zero, denorm, inf, nan, snan}
  task automatic run_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat,
                          input logic s_a, input logic [9:0] e_a, input logic [23:0] m_a,
                          input logic [4:0] f_a,
                          input logic s_b, input logic [9:0] e_b, input logic [23:0] m_b,
                          input logic [4:0] f_b, input logic inv);
    int lat;
    send(tag, a, b);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_sign_a"}, {31'd0, bus.sign_a}, {31'd0, s_a});
    check({tag, "_exp_a"}, {22'd0, bus.exp_a}, {22'd0, e_a});
    check({tag, "_mant_a"}, {8'd0, bus.mant_a}, {8'd0, m_a});
    check({tag, "_flags_a"},
          {27'd0, bus.zero_a, bus.denorm_a, bus.inf_a, bus.nan_a, bus.snan_a}, {27'd0, f_a});
    check({tag, "_sign_b"}, {31'd0, bus.sign_b}, {31'd0, s_b});
    check({tag, "_exp_b"}, {22'd0, bus.exp_b}, {22'd0, e_b});
    check({tag, "_mant_b"}, {8'd0, bus.mant_b}, {8'd0, m_b});
    check({tag, "_flags_b"},
          {27'd0, bus.zero_b, bus.denorm_b, bus.inf_b, bus.nan_b, bus.snan_b}, {27'd0, f_b});
    check({tag, "_inv"}, {31'd0, bus.out_inv}, {31'd0, inv});
  endtask

  initial begin
    int seen;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_exp_a", {22'd0, bus.exp_a}, 32'd0);
    check("rst_mant_b", {8'd0, bus.mant_b}, 32'd0);
    check("rst_inv", {31'd0, bus.out_inv}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal pair, then in_ready must return one cycle after the out handshake
    run_pair("one_two", 32'h3F80_0000, 32'h4000_0000, 1,
             1'b0, 10'd127, 24'h800000, 5'b00000,
             1'b0, 10'd128, 24'h800000, 5'b00000, 1'b0);
    @(posedge clk); #1;
    check("one_two_ready_back", {31'd0, bus.in_ready}, 32'd1);

    run_pair("min_denorm", 32'h0000_0001, 32'h3F80_0000, 24,
             1'b0, 10'h3EA, 24'h800000, 5'b01000,
             1'b0, 10'd127, 24'h800000, 5'b00000, 1'b0);
    run_pair("k1_k2", 32'h0040_0000, 32'h8020_0000, 3,
             1'b0, 10'h000, 24'h800000, 5'b01000,
             1'b1, 10'h3FF, 24'h800000, 5'b01000, 1'b0);
    run_pair("max_denorm", 32'h007F_FFFF, 32'h0000_0003, 23,
             1'b0, 10'h000, 24'hFFFFFE, 5'b01000,
             1'b0, 10'h3EB, 24'hC00000, 5'b01000, 1'b0);
    run_pair("inf_x_zero", 32'h7F80_0000, 32'h8000_0000, 1,
             1'b0, 10'd255, 24'h800000, 5'b00100,
             1'b1, 10'd0, 24'h000000, 5'b10000, 1'b1);
    run_pair("zero_x_inf", 32'h0000_0000, 32'hFF80_0000, 1,
             1'b0, 10'd0, 24'h000000, 5'b10000,
             1'b1, 10'd255, 24'h800000, 5'b00100, 1'b1);
    run_pair("snan", 32'h7FA0_0000, 32'h8000_0000, 1,
             1'b0, 10'd255, 24'hA00000, 5'b00011,
             1'b1, 10'd0, 24'h000000, 5'b10000, 1'b1);
    run_pair("qnan", 32'h7FC0_0000, 32'h3F80_0000, 1,
             1'b0, 10'd255, 24'hC00000, 5'b00010,
             1'b0, 10'd127, 24'h800000, 5'b00000, 1'b0);

    // Backpressure: DONE must hold while in_valid and op_a churn
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    run_pair("bp", 32'h3F80_0000, 32'h4000_0000, 1,
             1'b0, 10'd127, 24'h800000, 5'b00000,
             1'b0, 10'd128, 24'h800000, 5'b00000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.op_a     = $urandom_range(32'h0000_0001, 32'h7FFF_FFFF);
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_exp_a", {22'd0, bus.exp_a}, 32'd127);
      check("bp_mant_a", {8'd0, bus.mant_a}, 32'h0080_0000);
      check("bp_exp_b", {22'd0, bus.exp_b}, 32'd128);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset in the middle of normalization discards the pair
    send("rst_mid", 32'h0000_0001, 32'h3F80_0000);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_exp_a", {22'd0, bus.exp_a}, 32'd0);
    check("mid_rst_mant_a", {8'd0, bus.mant_a}, 32'd0);
    check("mid_rst_denorm_a", {31'd0, bus.denorm_a}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("mid_rst_no_present", seen, 0);
    run_pair("after_rst", 32'h3F80_0000, 32'h3F80_0000, 1,
             1'b0, 10'd127, 24'h800000, 5'b00000,
             1'b0, 10'd127, 24'h800000, 5'b00000, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
